fp32_div_mean: RTL and testbench



---
 rtl/fp32_div_mean.sv | 237 +++++++++++++++++++++++
 tb/tb_fp32_div_mean.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fp32_div_mean.sv
// fp32_div_mean: multicycle fp32 divide (x/y) / mean ((x+y)/2) engine for the Heron sqrt loop.
// Optional macro FP32_DIVMEAN_RNE_EN selects round-to-nearest-even; default truncates toward zero.
module fp32_div_mean (
  input  logic        clk,
  input  logic        rst,
  input  logic        op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        rdy,
  output logic [31:0] result
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  typedef struct packed {
    logic        sgn;
    logic [7:0]  exp;
    logic [23:0] man;
  } fp_t;

  // Denormals flush to signed zero: exponent 0 means mantissa 0.
  function automatic fp_t unpack(input logic [31:0] v);
    fp_t u;
    u.sgn = v[31];
    if (v[30:23] == 8'd0) begin
      u.exp = 8'd0;
      u.man = 24'd0;
    end else begin
      u.exp = v[30:23];
      u.man = {1'b1, v[22:0]};
    end
    return u;
  endfunction

  function automatic logic [9:0] rca10(input logic [9:0] a, input logic [9:0] b, input logic ci);
    logic [9:0] s;
    logic       c;
    c = ci;
    for (int i = 0; i < 10; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return s;
  endfunction

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic        op_q, last;
  fp_t         xq, yq;
  logic        spc_q;
  logic [31:0] spc_v_q;
  logic [25:0] rem;
  logic [23:0] dvs;
  logic [24:0] quo;
  logic [9:0]  e_q;
  logic        sgn_q, sub_q, zs_q;
  logic [26:0] ma_al, mb_al;
  logic [23:0] nm_man;
  logic        nm_g, nm_s, nm_zero;

  // operand classification and special-case results
  fp_t         ux, uy;
  logic        xz, yz, xi, yi, xn, yn, spc_c;
  logic [31:0] spc_v_c;

  assign ux = unpack(x);
  assign uy = unpack(y);
  assign xz = (x[30:23] == 8'd0);
  assign yz = (y[30:23] == 8'd0);
  assign xi = (&x[30:23]) & ~(|x[22:0]);
  assign yi = (&y[30:23]) & ~(|y[22:0]);
  assign xn = (&x[30:23]) & (|x[22:0]);
  assign yn = (&y[30:23]) & (|y[22:0]);

  always_comb begin
    spc_c   = 1'b1;
    spc_v_c = QNAN;
    if (xn || yn) spc_v_c = QNAN;
    else if (!op) begin
      if ((xz && yz) || (xi && yi)) spc_v_c = QNAN;
      else if (xi || yz)            spc_v_c = {x[31] ^ y[31], 31'h7F80_0000};
      else if (xz || yi)            spc_v_c = {x[31] ^ y[31], 31'd0};
      else                          spc_c   = 1'b0;
    end else begin
      if (xi && yi && (x[31] != y[31])) spc_v_c = QNAN;
      else if (xi)                      spc_v_c = x;
      else if (yi)                      spc_v_c = y;
      else                              spc_c   = 1'b0;
    end
  end

  // restoring-division trial subtract; after the last step it also yields the extra guard bit
  logic        d_ge;
  logic [25:0] d_sub;
  assign d_sub = rem - {2'b0, dvs};
  assign d_ge  = (rem >= {2'b0, dvs});

  // mean alignment: smaller magnitude shifted right, lost bits folded into sticky
  logic        x_big;
  fp_t         ua, ub;
  logic [7:0]  ediff;
  logic [4:0]  dsh;
  logic [53:0] sh;
  assign x_big = {xq.exp, xq.man} >= {yq.exp, yq.man};
  assign ua    = x_big ? xq : yq;
  assign ub    = x_big ? yq : xq;
  assign ediff = ua.exp - ub.exp;
  assign dsh   = (ediff > 8'd30) ? 5'd30 : ediff[4:0];
  assign sh    = {ub.man, 30'd0} >> dsh;

  logic [27:0] sum;
  logic [4:0]  lz;
  logic [26:0] nm27, shl;
  logic [9:0]  e_n;
  assign sum = sub_q ? ({1'b0, ma_al} - {1'b0, mb_al}) : ({1'b0, ma_al} + {1'b0, mb_al});

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
  end

  assign shl  = sum[26:0] << lz;
  assign nm27 = sum[27] ? {sum[27:2], sum[1] | sum[0]} : shl;
  // exponent already includes the halving: carry-out (+1-1) or e - lz - 1
  assign e_n  = sum[27] ? e_q : rca10(e_q, ~{5'd0, lz}, 1'b0);

  logic [24:0] rm;
  logic        inc;
  logic [9:0]  er;
  logic [31:0] res_c;
  logic        unused_bits;

  always_comb begin
`ifdef FP32_DIVMEAN_RNE_EN
    inc = nm_g & (nm_s | nm_man[0]);
`else
    inc = 1'b0;
`endif
    rm = {1'b0, nm_man} + {24'd0, inc};
    er = rm[24] ? rca10(e_q, 10'd0, 1'b1) : e_q;
    if (nm_zero) res_c = {sgn_q, 31'd0};
    else if ($signed(er) >= $signed(10'sd255))
`ifdef FP32_DIVMEAN_RNE_EN
      res_c = {sgn_q, 31'h7F80_0000};
`else
      res_c = {sgn_q, 31'h7F7F_FFFF};
`endif
    else if ($signed(er) <= $signed(10'sd0)) res_c = {sgn_q, 31'd0};
    else res_c = {sgn_q, er[7:0], rm[22:0]};
  end

  assign unused_bits = rm[23] ^ nm_g ^ nm_s;

  assign last = op_q ? (cnt == 5'd2) : (cnt == 5'd26);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; op_q <= 1'b0; xq <= '0; yq <= '0;
      spc_q <= 1'b0; spc_v_q <= '0;
      rem <= '0; dvs <= '0; quo <= '0; e_q <= '0;
      sgn_q <= 1'b0; sub_q <= 1'b0; zs_q <= 1'b0;
      ma_al <= '0; mb_al <= '0;
      nm_man <= '0; nm_g <= 1'b0; nm_s <= 1'b0; nm_zero <= 1'b0;
      rdy <= 1'b0; result <= '0;
    end else begin
      case (state)
        LOAD: begin
          op_q    <= op;
          xq      <= ux;
          yq      <= uy;
          spc_q   <= spc_c;
          spc_v_q <= spc_v_c;
          rem     <= {2'b0, ux.man};
          dvs     <= uy.man;
          quo     <= '0;
          e_q     <= rca10(rca10({2'b0, ux.exp}, ~{2'b0, uy.exp}, 1'b1), 10'd127, 1'b0);
          sgn_q   <= ux.sgn ^ uy.sgn;
          cnt     <= '0;
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (!op_q) begin
            if (cnt < 5'd25) begin
              quo <= {quo[23:0], d_ge};
              rem <= d_ge ? (d_sub << 1) : (rem << 1);
            end else if (cnt == 5'd25) begin
              nm_zero <= 1'b0;
              if (quo[24]) begin
                nm_man <= quo[24:1];
                nm_g   <= quo[0];
                nm_s   <= |rem;
              end else begin
                nm_man <= quo[23:0];
                nm_g   <= d_ge;
                nm_s   <= |(d_ge ? d_sub : rem);
                e_q    <= rca10(e_q, 10'h3FF, 1'b0);
              end
            end
          end else if (cnt == 5'd0) begin
            ma_al <= {ua.man, 3'd0};
            mb_al <= {sh[53:28], sh[27] | (|sh[26:0])};
            e_q   <= {2'b0, ua.exp};
            sgn_q <= ua.sgn;
            sub_q <= ua.sgn ^ ub.sgn;
            zs_q  <= xq.sgn & yq.sgn;
          end else if (cnt == 5'd1) begin
            nm_man  <= nm27[26:3];
            nm_g    <= nm27[2];
            nm_s    <= |nm27[1:0];
            nm_zero <= (sum == 28'd0);
            e_q     <= e_n;
            if (sum == 28'd0) sgn_q <= zs_q;
          end
          if (last) begin
            rdy    <= 1'b1;
            result <= spc_q ? spc_v_q : res_c;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_div_mean.sv
// Bench for fp32_div_mean: exact-integer reference model, per-cycle output check, directed vectors.
module tb_fp32_div_mean;
  logic        clk = 1'b0, rst = 1'b0, op = 1'b0, rdy;
  logic [31:0] x = '0, y = '0, result;
  int          n = 0, nerr = 0, nchk = 0;
  logic        cur_op = 1'b0, chk_en = 1'b0, e_rdy;
  logic [31:0] exp_val = '0;

`ifdef FP32_DIVMEAN_RNE_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB, OVF = 32'h7F800000, MSUB = 32'h3F000000;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA, OVF = 32'h7F7FFFFF, MSUB = 32'h3EFFFFFF;
`endif

  fp32_div_mean dut (.clk(clk), .rst(rst), .op(op), .x(x), .y(y), .rdy(rdy), .result(result));

  always #5 clk = ~clk;

  // edges since rst release: n=1 is the load edge
  always @(posedge clk or posedge rst)
    if (rst) n <= 0;
    else if (n < 1000) n <= n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] pack(input logic s, input int e, input longint mant,
                                        input logic g, input logic st);
    longint m;
    int     ee;
    m  = mant;
    ee = e;
`ifdef FP32_DIVMEAN_RNE_EN
    if (g && (st || m[0])) m = m + 1;
    if (m == (64'sd1 << 24)) begin m = m >> 1; ee = ee + 1; end
    if (ee >= 255) return {s, 31'h7F800000};
`else
    if (ee >= 255) return {s, 31'h7F7FFFFF};
`endif
    if (ee <= 0) return {s, 31'd0};
    return {s, ee[7:0], m[22:0]};
  endfunction

  // take the top 24 bits of a positive integer, plus guard and sticky
  function automatic void nrm(input longint v, output longint m, output logic g,
                              output logic st, output int p);
    p = 0;
    for (int i = 0; i < 63; i++) if (v[i]) p = i;
    m  = v >> (p - 23);
    g  = v[p - 24];
    st = (v & ((64'sd1 << (p - 24)) - 1)) != 0;
  endfunction

  function automatic logic [31:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
    logic   sa, sb, za, zb, ia, ib, na, nb, ts, g, st;
    int     ea, eb, d, p, te;
    longint ma, mb, tm, q, r, va, vb, s, mag, m;
    sa = a[31]; sb = b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0); ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0); nb = (eb == 255) && (b[22:0] != 0);
    ma = za ? 64'sd0 : longint'({1'b1, a[22:0]});
    mb = zb ? 64'sd0 : longint'({1'b1, b[22:0]});
    if (na || nb) return 32'h7FC00000;
    if (!o) begin
      if ((za && zb) || (ia && ib)) return 32'h7FC00000;
      if (ia || zb) return {sa ^ sb, 31'h7F800000};
      if (za || ib) return {sa ^ sb, 31'd0};
      q = (ma << 26) / mb;
      r = (ma << 26) % mb;
      nrm(q, m, g, st, p);
      st = st || (r != 0);
      return pack(sa ^ sb, ea - eb + 127 + (p - 26), m, g, st);
    end
    if (ia && ib && (sa != sb)) return 32'h7FC00000;
    if (ia) return a;
    if (ib) return b;
    if (eb > ea) begin
      ts = sa; sa = sb; sb = ts;
      te = ea; ea = eb; eb = te;
      tm = ma; ma = mb; mb = tm;
    end
    d  = ea - eb;
    va = sa ? -(ma << 30) : (ma << 30);
    if (mb == 0)    vb = 0;
    else if (d > 30) vb = 1;
    else            vb = mb << (30 - d);
    if (sb) vb = -vb;
    s = va + vb;
    if (s == 0) return {sa & sb, 31'd0};
    mag = (s < 0) ? -s : s;
    nrm(mag, m, g, st, p);
    return pack(s < 0, ea + (p - 53) - 1, m, g, st);
  endfunction

  // every cycle: cleared during rst, zero before the latency, model value after
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        chk("rst_rdy", {31'd0, rdy}, 32'd0);
        chk("rst_result", result, 32'd0);
      end else begin
        e_rdy = (n >= (cur_op ? 4 : 28));
        chk($sformatf("cyc_rdy@n=%0d", n), {31'd0, rdy}, {31'd0, e_rdy});
        chk($sformatf("cyc_result@n=%0d", n), result, e_rdy ? exp_val : 32'd0);
      end
    end
  end

  task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pin, input string nm);
    @(posedge clk); #2;
    rst = 1'b1; op = o; x = a; y = b; cur_op = o;
    exp_val = model(o, a, b);
    #1;
    chk({nm, "_clr_rdy"}, {31'd0, rdy}, 32'd0);
    chk({nm, "_clr_res"}, result, 32'd0);
    chk({nm, "_model"}, exp_val, pin);
    repeat (2) @(posedge clk);
    #2; rst = 1'b0;
    @(posedge clk); #2;
    op = ~o; x = ~a; y = ~b;
    repeat (o ? 5 : 29) @(posedge clk);
    #2;
    chk({nm, "_rdy"}, {31'd0, rdy}, 32'd1);
    chk({nm, "_res"}, result, pin);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_rdy", {31'd0, rdy}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk_en = 1'b1;

    run(1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, "div_6_2");
    run(1'b0, 32'h3F800000, 32'h40400000, THIRD,        "div_1_3");
    run(1'b1, 32'h40000000, 32'h40800000, 32'h40400000, "mean_2_4");
    run(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, "mean_max");
    run(1'b1, 32'h3F800000, 32'hBF800000, 32'h00000000, "mean_cancel");
    run(1'b1, 32'h80000000, 32'h80000000, 32'h80000000, "mean_negzero");
    run(1'b1, 32'h3F800000, 32'h40400000, 32'h40000000, "mean_1_3");
    run(1'b1, 32'h3F800000, 32'hAB800000, MSUB,         "mean_tiny_sub");
    run(1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000, "mean_inf_ninf");
    run(1'b1, 32'h7F800000, 32'h3F800000, 32'h7F800000, "mean_inf");
    run(1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, "div_by_zero");
    run(1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, "div_0_0");
    run(1'b0, 32'h00400000, 32'h3F800000, 32'h00000000, "div_denorm");
    run(1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, "div_nan");
    run(1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, "div_ninf_2");
    run(1'b0, 32'h40000000, 32'hFF800000, 32'h80000000, "div_2_ninf");
    run(1'b0, 32'h7F000000, 32'h3E800000, OVF,          "div_ovf");
    run(1'b0, 32'h00800000, 32'h40000000, 32'h00000000, "div_unf");

    // abort between edges 10 and 11, then restart
    @(posedge clk); #2;
    rst = 1'b1; op = 1'b0; x = 32'h40C00000; y = 32'h40000000; cur_op = 1'b0;
    exp_val = model(1'b0, 32'h40C00000, 32'h40000000);
    @(posedge clk); #2; rst = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    chk("abort_rdy", {31'd0, rdy}, 32'd0);
    chk("abort_res", result, 32'd0);
    @(posedge clk); #2; rst = 1'b0;
    repeat (27) @(posedge clk);
    #2;
    chk("abort_early_rdy", {31'd0, rdy}, 32'd0);
    @(posedge clk); #2;
    chk("abort_rdy_final", {31'd0, rdy}, 32'd1);
    chk("abort_res_final", result, 32'h40400000);
    repeat (2) @(posedge clk);
    #2;

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", nerr, nchk);
    $fatal(1, "watchdog");
  end
endmodule
